branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumer of the ID-stage branch comparator flags: evaluates the branch condition, then sequences the PC redirect to fetch with delay-slot awareness.
- Takes the decoded branch op plus the comparator outputs (inequality, four sign flags) and the precomputed targets.
- Holds the redirect until the delay-slot instruction has been fetched and IF accepts it.
- Sits between ID and IF; handles branch-likely annulment, JR misalignment and exception flush.

Parameters:
- PC_W, 32, width of PC and target addresses.
- RESET_PC, 32'hBFC0_0000, value of redirect_pc after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  branch/jump in ID is valid this cycle.
- id_br_op  in  4  branch op (package encoding).
- id_likely  in  1  branch-likely variant.
- cmp_ne  in  1  1 = rs != rt.
- cmp_sign  in  4  [3] rs>=0, [2] rs<0, [1] rs>0, [0] rs<=0.
- br_target  in  PC_W  PC-relative or J-type target.
- jr_target  in  PC_W  rs value for JR/JALR.
- ds_fetched  in  1  delay-slot instruction has left IF.
- if_ready  in  1  IF accepts a redirect this cycle.
- flush  in  1  exception/ERET flush.
- id_stall  out  1  hold ID; branch cannot be accepted.
- redirect_valid  out  1  redirect request to IF.
- redirect_pc  out  PC_W  redirect address.
- ds_annul  out  1  one-cycle pulse: kill delay slot (likely, not taken).
- adel_req  out  1  one-cycle pulse: misaligned JR target.

Behaviour:
- Reset: state IDLE; redirect_valid=0, redirect_pc=RESET_PC, ds_annul=0, adel_req=0, id_stall=0.
- Taken decode (combinational):
  - BEQ: !cmp_ne.
  - BNE: cmp_ne.
  - BGEZ/BLTZ/BGTZ/BLEZ: cmp_sign[3]/[2]/[1]/[0].
  - J, JR: 1.
  - BR_NONE: no accept.
  - Undefined ops are treated as BR_NONE.
- Accept: id_valid && id_br_op!=BR_NONE && state==IDLE && !flush.
- States IDLE, WAIT_DS, REDIRECT.
  - IDLE, accept, taken, target aligned: latch target (JR uses jr_target, others br_target) into redirect_pc.
    - ds_fetched=1: go to REDIRECT.
    - ds_fetched=0: go to WAIT_DS.
  - IDLE, accept, JR with jr_target[1:0]!=0: adel_req=1 next cycle; stay IDLE; no redirect.
  - IDLE, accept, not taken:
    - id_likely=1: ds_annul=1 next cycle.
    - Either way, stay IDLE.
  - WAIT_DS: go to REDIRECT on the first cycle ds_fetched=1.
  - REDIRECT: redirect_valid=1 (registered, asserted the cycle REDIRECT is entered); redirect_pc stable. Return to IDLE in the cycle after if_ready=1; redirect_valid drops in that same cycle.
- Latency: condition to redirect_valid is 1 cycle when ds_fetched=1 at accept; otherwise 1 cycle after ds_fetched rises.
- id_stall = id_valid && id_br_op!=BR_NONE && state!=IDLE. An unaccepted branch is re-presented by ID unchanged.
- flush has highest priority:
  - Any state goes to IDLE next cycle; redirect_valid, ds_annul and adel_req are 0 next cycle.
  - A branch presented the same cycle is dropped.
  - redirect_pc retains its value.
- Simultaneous REDIRECT && if_ready && new branch: the new branch stalls that cycle and is accepted the next cycle (IDLE).
- ds_annul and adel_req are never high together and never high while redirect_valid=1.
- Reset mid-operation (any state) behaves exactly as power-on reset.

Decomposition:
- Package branch_pkg:
  - op codes: BR_NONE=0, BR_BEQ=1, BR_BNE=2, BR_BGEZ=3, BR_BLTZ=4, BR_BGTZ=5, BR_BLEZ=6, BR_J=7, BR_JR=8.
  - state enum.
  - cmp_sign bit indices.
- One sub-module, br_cond_eval: purely combinational taken decode from op, cmp_ne and cmp_sign. The FSM and registers stay in branch_resolve.

Test Plan:
- Reset mid-REDIRECT: rst=1 for 1 cycle -> next cycle state IDLE, redirect_valid=0, redirect_pc=32'hBFC0_0000.
- BEQ, cmp_ne=0, br_target=32'h8000_0100, ds_fetched=1, if_ready=1 -> redirect_valid=1 with redirect_pc=32'h8000_0100 one cycle later, low the cycle after.
- BGTZ, cmp_sign=4'b1010, ds_fetched=0 for 3 cycles then 1 -> WAIT_DS for 3 cycles; redirect_valid rises the cycle after ds_fetched; id_stall=1 for a second branch meanwhile.
- BNE likely, cmp_ne=0 -> ds_annul single-cycle pulse, no redirect_valid.
- JR, jr_target=32'h8000_0102 -> adel_req pulse, redirect_valid stays 0.
- REDIRECT with if_ready=0 for 4 cycles, flush=1 on cycle 2 -> redirect_valid=0 from cycle 3, state IDLE, no further redirect.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch resolver.
package branch_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BGEZ = 4'd3;
    localparam logic [3:0] BR_BLTZ = 4'd4;
    localparam logic [3:0] BR_BGTZ = 4'd5;
    localparam logic [3:0] BR_BLEZ = 4'd6;
    localparam logic [3:0] BR_J    = 4'd7;
    localparam logic [3:0] BR_JR   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam int SGN_GEZ = 3;
    localparam int SGN_LTZ = 2;
    localparam int SGN_GTZ = 1;
    localparam int SGN_LEZ = 0;

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational taken decode from the branch op and comparator flags.
module br_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] op,
    input  logic       cmp_ne,
    input  logic [3:0] cmp_sign,
    output logic       is_branch,
    output logic       taken
);

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (op)
            BR_BEQ:  taken = !cmp_ne;
            BR_BNE:  taken = cmp_ne;
            BR_BGEZ: taken = cmp_sign[SGN_GEZ];
            BR_BLTZ: taken = cmp_sign[SGN_LTZ];
            BR_BGTZ: taken = cmp_sign[SGN_GTZ];
            BR_BLEZ: taken = cmp_sign[SGN_LEZ];
            BR_J:    taken = 1'b1;
            BR_JR:   taken = 1'b1;
            // undefined encodings fall back to no-branch
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver: evaluates the condition and sequences a
// delay-slot-aware PC redirect to fetch.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [3:0]      id_br_op,
    input  logic            id_likely,
    input  logic            cmp_ne,
    input  logic [3:0]      cmp_sign,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] jr_target,
    input  logic            ds_fetched,
    input  logic            if_ready,
    input  logic            flush,
    output logic            id_stall,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            ds_annul,
    output logic            adel_req
);

    state_t state;
    logic   is_branch;
    logic   taken;
    logic   is_jr;
    logic   misalign;
    logic   accept;

    logic [PC_W-1:0] target;

    br_cond_eval u_cond (
        .op        (id_br_op),
        .cmp_ne    (cmp_ne),
        .cmp_sign  (cmp_sign),
        .is_branch (is_branch),
        .taken     (taken)
    );

    assign is_jr    = (id_br_op == BR_JR);
    assign misalign = is_jr && (jr_target[1:0] != 2'b00);
    assign target   = is_jr ? jr_target : br_target;
    assign accept   = id_valid && is_branch
                   && (state == ST_IDLE) && !flush;
    assign id_stall = id_valid && is_branch && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            ds_annul       <= 1'b0;
            adel_req       <= 1'b0;
        end else begin
            ds_annul <= 1'b0;
            adel_req <= 1'b0;
            if (flush) begin
                state          <= ST_IDLE;
                redirect_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (misalign) begin
                                adel_req <= 1'b1;
                            end else if (taken) begin
                                redirect_pc <= target;
                                if (ds_fetched) begin
                                    state          <= ST_REDIRECT;
                                    redirect_valid <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_DS;
                                end
                            end else if (id_likely) begin
                                ds_annul <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_DS: begin
                        if (ds_fetched) begin
                            state          <= ST_REDIRECT;
                            redirect_valid <= 1'b1;
                        end
                    end
                    ST_REDIRECT: begin
                        if (if_ready) begin
                            state          <= ST_IDLE;
                            redirect_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_br_op;
    logic        id_likely;
    logic        cmp_ne;
    logic [3:0]  cmp_sign;
    logic [31:0] br_target;
    logic [31:0] jr_target;
    logic        ds_fetched;
    logic        if_ready;
    logic        flush;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ds_annul;
    logic        adel_req;

    int tests = 0;
    int fails = 0;

    branch_resolve dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_br_op       (id_br_op),
        .id_likely      (id_likely),
        .cmp_ne         (cmp_ne),
        .cmp_sign       (cmp_sign),
        .br_target      (br_target),
        .jr_target      (jr_target),
        .ds_fetched     (ds_fetched),
        .if_ready       (if_ready),
        .flush          (flush),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ds_annul       (ds_annul),
        .adel_req       (adel_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rv,
                           input logic [31:0] pc, input logic an,
                           input logic ad);
        chk({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, ".pc"}, redirect_pc, pc);
        chk({tag, ".annul"}, {31'd0, ds_annul}, {31'd0, an});
        chk({tag, ".adel"}, {31'd0, adel_req}, {31'd0, ad});
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_br_op = 4'd0;
        id_likely = 1'b0; cmp_ne = 1'b0; cmp_sign = 4'd0;
        br_target = 32'd0; jr_target = 32'd0;
        ds_fetched = 1'b0; if_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
        chk("reset.stall", {31'd0, id_stall}, 32'd0);

        // BEQ taken with delay slot already fetched
        id_valid = 1'b1; id_br_op = 4'd1; cmp_ne = 1'b0;
        br_target = 32'h8000_0100; ds_fetched = 1'b1; if_ready = 1'b1;
        tick();
        chk_out("beq", 1'b1, 32'h8000_0100, 1'b0, 1'b0);
        chk("beq.stall", {31'd0, id_stall}, 32'd1);
        id_valid = 1'b0;
        tick();
        chk_out("beq.drop", 1'b0, 32'h8000_0100, 1'b0, 1'b0);

        // BGTZ taken, delay slot late
        id_valid = 1'b1; id_br_op = 4'd5; cmp_sign = 4'b1010;
        br_target = 32'h8000_0200; ds_fetched = 1'b0; if_ready = 1'b0;
        tick();
        chk_out("bgtz.w1", 1'b0, 32'h8000_0200, 1'b0, 1'b0);
        id_br_op = 4'd1;
        #1;
        chk("bgtz.stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk_out("bgtz.w2", 1'b0, 32'h8000_0200, 1'b0, 1'b0);
        tick();
        chk_out("bgtz.w3", 1'b0, 32'h8000_0200, 1'b0, 1'b0);
        ds_fetched = 1'b1;
        tick();
        chk_out("bgtz.rd", 1'b1, 32'h8000_0200, 1'b0, 1'b0);
        id_valid = 1'b0; if_ready = 1'b1;
        tick();
        chk_out("bgtz.done", 1'b0, 32'h8000_0200, 1'b0, 1'b0);

        // BNE likely, not taken: annul pulse
        id_valid = 1'b1; id_br_op = 4'd2; id_likely = 1'b1; cmp_ne = 1'b0;
        tick();
        chk_out("bnel", 1'b0, 32'h8000_0200, 1'b1, 1'b0);
        id_valid = 1'b0;
        tick();
        chk_out("bnel.end", 1'b0, 32'h8000_0200, 1'b0, 1'b0);

        // BLTZ likely, not taken via sign flag
        id_valid = 1'b1; id_br_op = 4'd4; cmp_sign = 4'b1010;
        tick();
        chk_out("bltzl", 1'b0, 32'h8000_0200, 1'b1, 1'b0);
        id_valid = 1'b0; id_likely = 1'b0;
        tick();

        // JR misaligned
        id_valid = 1'b1; id_br_op = 4'd8; jr_target = 32'h8000_0102;
        tick();
        chk_out("jr.adel", 1'b0, 32'h8000_0200, 1'b0, 1'b1);
        id_valid = 1'b0;
        tick();
        chk_out("jr.end", 1'b0, 32'h8000_0200, 1'b0, 1'b0);

        // Aligned JR uses jr_target
        id_valid = 1'b1; id_br_op = 4'd8; jr_target = 32'h8000_0A00;
        br_target = 32'h1111_1110; ds_fetched = 1'b1; if_ready = 1'b1;
        tick();
        chk_out("jr.ok", 1'b1, 32'h8000_0A00, 1'b0, 1'b0);
        id_valid = 1'b0;
        tick();

        // Undefined op: no accept, no stall
        id_valid = 1'b1; id_br_op = 4'hF;
        #1;
        chk("undef.stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk_out("undef", 1'b0, 32'h8000_0A00, 1'b0, 1'b0);
        id_valid = 1'b0;

        // Flush while REDIRECT held by if_ready=0
        id_valid = 1'b1; id_br_op = 4'd7; br_target = 32'h8000_0300;
        ds_fetched = 1'b1; if_ready = 1'b0;
        tick();
        chk_out("fl.c1", 1'b1, 32'h8000_0300, 1'b0, 1'b0);
        id_valid = 1'b0;
        tick();
        chk_out("fl.c2", 1'b1, 32'h8000_0300, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        chk_out("fl.c3", 1'b0, 32'h8000_0300, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        chk_out("fl.c4", 1'b0, 32'h8000_0300, 1'b0, 1'b0);

        // Branch presented during flush in IDLE is dropped
        id_valid = 1'b1; id_br_op = 4'd1; cmp_ne = 1'b0;
        br_target = 32'h8000_0700; flush = 1'b1;
        tick();
        chk_out("fl.drop", 1'b0, 32'h8000_0300, 1'b0, 1'b0);
        id_valid = 1'b0; flush = 1'b0;
        tick();
        chk_out("fl.drop2", 1'b0, 32'h8000_0300, 1'b0, 1'b0);

        // New branch while REDIRECT completes
        id_valid = 1'b1; id_br_op = 4'd7; br_target = 32'h8000_0400;
        if_ready = 1'b0;
        tick();
        chk_out("bb.r1", 1'b1, 32'h8000_0400, 1'b0, 1'b0);
        id_br_op = 4'd1; cmp_ne = 1'b0; br_target = 32'h8000_0500;
        if_ready = 1'b1;
        #1;
        chk("bb.stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk_out("bb.idle", 1'b0, 32'h8000_0400, 1'b0, 1'b0);
        chk("bb.nostall", {31'd0, id_stall}, 32'd0);
        tick();
        chk_out("bb.r2", 1'b1, 32'h8000_0500, 1'b0, 1'b0);
        id_valid = 1'b0;
        tick();

        // Reset mid-REDIRECT
        id_valid = 1'b1; id_br_op = 4'd7; br_target = 32'h8000_0600;
        if_ready = 1'b0;
        tick();
        chk_out("rs.r", 1'b1, 32'h8000_0600, 1'b0, 1'b0);
        id_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rs.idle", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
        id_valid = 1'b1; id_br_op = 4'd1; cmp_ne = 1'b1;
        #1;
        chk("rs.state", {31'd0, id_stall}, 32'd0);
        tick();
        chk_out("rs.nt", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
        id_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
